// File: rtl/four_bit_bidirectional_serializer.sv
// Valid/ready parallel-in, serial-out transmitter feeding the 4-bit bidirectional shift register.
// Optional even-parity bit after the data bits when SER_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a word, load_ready=1, serial_out=0
// SHIFT  | data bits going out, one per DIV_COUNT clocks
// PARITY | even-parity bit of the captured word (SER_PARITY_EN only)
module four_bit_bidirectional_serializer #(
    parameter int WIDTH     = 4,
    parameter int DIV_COUNT = 75000000
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    output logic             serial_out,
    output logic             shift_strb,
    output logic             busy,
    output logic             done
);
    localparam int DW = $clog2(DIV_COUNT);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COUNT - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(DIV_COUNT - 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic parity_r;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             mode_r;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= IDLE;
            shreg      <= '0;
            mode_r     <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            serial_out <= 1'b0;
            shift_strb <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef SER_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            shift_strb <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state      <= SHIFT;
                        shreg      <= din;
                        mode_r     <= mode;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        serial_out <= mode ? din[0] : din[WIDTH-1];
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
`ifdef SER_PARITY_EN
                        parity_r   <= ^din;
`endif
                    end
                end
                SHIFT: begin
                    // strobe is registered, so it is raised one cycle before the last count
                    shift_strb <= (div_cnt == DIV_PRE);
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= mode_r ? (shreg >> 1) : (shreg << 1);
                        if (bit_cnt == BIT_LAST) begin
`ifdef SER_PARITY_EN
                            state      <= PARITY;
                            serial_out <= parity_r;
`else
                            state      <= IDLE;
                            serial_out <= 1'b0;
                            busy       <= 1'b0;
                            load_ready <= 1'b1;
                            done       <= 1'b1;
`endif
                        end else begin
                            serial_out <= mode_r ? shreg[1] : shreg[WIDTH-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
`ifdef SER_PARITY_EN
                PARITY: begin
                    shift_strb <= (div_cnt == DIV_PRE);
                    if (div_cnt == DIV_LAST) begin
                        div_cnt    <= '0;
                        state      <= IDLE;
                        serial_out <= 1'b0;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                        done       <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
